wishbone_sram_bridge: RTL and testbench
=======================================

# wishbone_sram_bridge

Parametrised Wishbone-classic slave bridging the Caravel user bus to one OpenRAM macro with an RW port (port 0) and an R port (port 1). Successor of the fixed single-macro wrapper: generalised in address width, row count and read-port mapping mode. It adds a base-address decode, registered SRAM control, a programmable read-capture latency, out-of-range handling and clean abort on `wbs_cyc_i` drop. Sits between the user-project Wishbone interconnect and each SRAM macro instance.

## Interface

- `BASE_ADDR`, 32'h3000_0000: byte base address; bits above `ADDR_WIDTH+2` are decoded.
- `ADDR_WIDTH`, 8: SRAM row address width.
- `NUM_ROWS`, 256: populated rows; must be ≤ 2^`ADDR_WIDTH`, even, ≥ 2.
- `MODE`, 1: read-port mapping.
  - 0 = all accesses on port 0.
  - 1 = lower half of rows on port 0, upper half on port 1.
  - 2 = even rows on port 0, odd rows on port 1.
- `READ_LATENCY`, 1: clock edges from the SRAM sampling a read to the bridge capturing dout. Range 1..3.

Ports:
- `wb_clk_i`, in, 1: the only clock; all logic is rising-edge.
- `wb_rst_ni`, in, 1: reset, synchronous, active-low.
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i`, in, 1 each: Wishbone strobe, cycle and write enable.
- `wbs_sel_i`, in, 4: byte selects.
- `wbs_adr_i`, in, 32: byte address.
- `wbs_dat_i`, in, 32: write data.
- `wbs_ack_o`, out, 1: one-cycle acknowledge.
- `wbs_dat_o`, out, 32: registered read data.
- `oor_o`, out, 1: sticky flag, set on any out-of-range access.
- `ram_clk0`, `ram_clk1`, out, 1: equal to `wb_clk_i`.
- `ram_csb0`, `ram_web0`, out, 1: port 0 chip select and write enable, active-low.
- `ram_wmask0`, out, 4: port 0 byte write mask.
- `ram_addr0`, out, `ADDR_WIDTH`: port 0 row address.
- `ram_dout0`, out, 32: data to the SRAM.
- `ram_din0`, in, 32: data from the SRAM, port 0.
- `ram_csb1`, out, 1: port 1 chip select, active-low.
- `ram_addr1`, out, `ADDR_WIDTH`: port 1 row address.
- `ram_din1`, in, 32: data from the SRAM, port 1.

## Operation

- Request: `req = wbs_stb_i & wbs_cyc_i`. Word index `w = wbs_adr_i[ADDR_WIDTH+1:2]`.
- In range when both hold:
  - `wbs_adr_i[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`
  - `w < NUM_ROWS`
- Port select, writes: always port 0.
- Port select, reads:
  - MODE 0: port 0.
  - MODE 1: port 1 iff `w ≥ NUM_ROWS/2`.
  - MODE 2: port 1 iff `w[0]`.
- Both `ram_addr*` carry `w` (full index, no remapping).
- All `ram_*` outputs except the clocks are registered.
- FSM states: IDLE, ACCESS, WAIT, ACK.
- IDLE:
  - `req` and in range: load the SRAM control registers for the selected port only (other csb stays 1) → ACCESS.
  - `req` and out of range: set `oor_o`, load `wbs_dat_o` = 0 → ACK. No SRAM access.
- ACCESS (SRAM samples at the end of this cycle): csb returns to 1 at the exiting edge.
  - Write → ACK.
  - Read → WAIT, with the latency counter loaded to `READ_LATENCY-1`.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: capture the selected port's `ram_din` into `wbs_dat_o` → ACK.
- ACK: `wbs_ack_o`=1 for exactly one cycle → IDLE.
- Abort: `wbs_cyc_i`=0 in ACCESS or WAIT → IDLE, no ack, csb forced 1, `wbs_dat_o` unchanged. A write already sampled by the SRAM still completes.
- `wbs_dat_o` holds its value until the next read capture or out-of-range access. Write acks leave it unchanged.
- Reset (`wb_rst_ni`=0 at a rising edge), from any state including mid-transaction:
  - State → IDLE.
  - `ram_csb0`=`ram_csb1`=`ram_web0`=1.
  - `ram_wmask0`=0, `ram_addr*`=0, `ram_dout0`=0.
  - `wbs_ack_o`=0, `wbs_dat_o`=0, `oor_o`=0.

## Timing

- Edges E0, E1, … Request present before E0 with the FSM in IDLE.
- Write: csb0/web0 low during E0–E1; SRAM writes at E1; `wbs_ack_o` high during E1–E2.
- Read: SRAM samples at E1; capture at E(1+`READ_LATENCY`); ack in the following cycle. Ack latency from E0 = 1+`READ_LATENCY` cycles.
- Out of range: ack high during E0–E1.
- No new request is accepted until the cycle after ack, so there are no back-to-back acks. `req` still high in the cycle after ack is treated as a new request.
- csb is low for exactly one cycle per access.

## Test plan

- Reset held low 3 cycles mid-read → all outputs at reset values, no ack. After release, a read of row 0 returns the value written earlier.
- MODE 1, NUM_ROWS=256, BASE 0x3000_0000:
  - Write 0xA5A5_1234 to 0x3000_0010, sel=4'b0011 → port 0 row 4, wmask 0011, ack at E1–E2.
  - Read 0x3000_0200 (row 128) → only `ram_csb1` low, ack after 1+RL cycles, data = `ram_din1`.
- MODE 2: read row 5 → port 1; read row 6 → port 0. Sweep READ_LATENCY 1..3 and check ack cycle counts 2, 3, 4.
- Access 0x3100_0000 and row 300 (NUM_ROWS=256) → ack at E0–E1, `wbs_dat_o`=0, no csb activity, `oor_o` sticky 1.
- Drop `wbs_cyc_i` in WAIT → no ack, FSM back in IDLE. The next read completes normally.

Source files
------------

// File: rtl/wishbone_sram_bridge.sv
// Wishbone-classic slave bridging the user bus to one OpenRAM macro (RW port 0, R port 1).
// Registered SRAM control, programmable read-capture latency and a sticky out-of-range flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a request; decodes range and selects the port
// S_ACCESS | SRAM control registers asserted, macro samples at exit edge
// S_WAIT   | read latency countdown, captures dout when counter is zero
// S_ACK    | one-cycle acknowledge back to the bus
module wishbone_sram_bridge #(
    parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
    parameter int          ADDR_WIDTH   = 8,
    parameter int          NUM_ROWS     = 256,
    parameter int          MODE         = 1,
    parameter int          READ_LATENCY = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_ni,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic                  wbs_ack_o,
    output logic [31:0]           wbs_dat_o,
    output logic                  oor_o,
    output logic                  ram_clk0,
    output logic                  ram_csb0,
    output logic                  ram_web0,
    output logic [3:0]            ram_wmask0,
    output logic [ADDR_WIDTH-1:0] ram_addr0,
    output logic [31:0]           ram_dout0,
    input  logic [31:0]           ram_din0,
    output logic                  ram_clk1,
    output logic                  ram_csb1,
    output logic [ADDR_WIDTH-1:0] ram_addr1,
    input  logic [31:0]           ram_din1
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

    localparam int                  TAG_LSB  = ADDR_WIDTH + 2;
    localparam int                  HALF_I   = NUM_ROWS / 2;
    localparam int                  LAT_I    = READ_LATENCY - 1;
    localparam logic [ADDR_WIDTH:0] ROWS     = NUM_ROWS[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] HALF     = HALF_I[ADDR_WIDTH:0];
    localparam logic [1:0]          LAT_INIT = LAT_I[1:0];

    state_t                  state_q, state_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    port1_q, port1_d;
    logic                    we_q, we_d;
    logic                    csb0_d, csb1_d, web0_d, ack_d, oor_d;
    logic [3:0]              wmask0_d;
    logic [ADDR_WIDTH-1:0]   addr0_d, addr1_d;
    logic [31:0]             dout0_d, dat_d;

    logic                    req, tag_hit, in_range, rd_port1;
    logic [ADDR_WIDTH-1:0]   word;
    logic                    unused_adr;

    assign ram_clk0   = wb_clk_i;
    assign ram_clk1   = wb_clk_i;
    assign unused_adr = ^wbs_adr_i[1:0];

    assign req      = wbs_stb_i & wbs_cyc_i;
    assign word     = wbs_adr_i[ADDR_WIDTH+1:2];
    assign tag_hit  = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign in_range = tag_hit && ({1'b0, word} < ROWS);

    always_comb begin
        rd_port1 = 1'b0;
        if (MODE == 1) begin
            rd_port1 = ({1'b0, word} >= HALF);
        end else if (MODE == 2) begin
            rd_port1 = word[0];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            port1_q    <= 1'b0;
            we_q       <= 1'b0;
            ram_csb0   <= 1'b1;
            ram_csb1   <= 1'b1;
            ram_web0   <= 1'b1;
            ram_wmask0 <= '0;
            ram_addr0  <= '0;
            ram_addr1  <= '0;
            ram_dout0  <= '0;
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            oor_o      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            port1_q    <= port1_d;
            we_q       <= we_d;
            ram_csb0   <= csb0_d;
            ram_csb1   <= csb1_d;
            ram_web0   <= web0_d;
            ram_wmask0 <= wmask0_d;
            ram_addr0  <= addr0_d;
            ram_addr1  <= addr1_d;
            ram_dout0  <= dout0_d;
            wbs_ack_o  <= ack_d;
            wbs_dat_o  <= dat_d;
            oor_o      <= oor_d;
        end
    end

    // Chip selects default high so every access asserts csb for exactly one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        port1_d  = port1_q;
        we_d     = we_q;
        csb0_d   = 1'b1;
        csb1_d   = 1'b1;
        web0_d   = 1'b1;
        wmask0_d = ram_wmask0;
        addr0_d  = ram_addr0;
        addr1_d  = ram_addr1;
        dout0_d  = ram_dout0;
        ack_d    = 1'b0;
        dat_d    = wbs_dat_o;
        oor_d    = oor_o;
        case (state_q)
            S_IDLE: begin
                if (req && in_range) begin
                    we_d    = wbs_we_i;
                    state_d = S_ACCESS;
                    if (wbs_we_i) begin
                        port1_d  = 1'b0;
                        csb0_d   = 1'b0;
                        web0_d   = 1'b0;
                        wmask0_d = wbs_sel_i;
                        addr0_d  = word;
                        dout0_d  = wbs_dat_i;
                    end else begin
                        port1_d = rd_port1;
                        if (rd_port1) begin
                            csb1_d  = 1'b0;
                            addr1_d = word;
                        end else begin
                            csb0_d   = 1'b0;
                            wmask0_d = '0;
                            addr0_d  = word;
                        end
                    end
                end else if (req) begin
                    oor_d   = 1'b1;
                    dat_d   = '0;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACCESS: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (we_q) begin
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d   = LAT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wbs_cyc_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q != 2'd0) begin
                    cnt_d = cnt_q - 2'd1;
                end else begin
                    dat_d   = port1_q ? ram_din1 : ram_din0;
                    ack_d   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wishbone_sram_bridge.sv
// Bench for wishbone_sram_bridge: six parameter variants, each with its own SRAM stand-in,
// reference memory, expectation queue and monitor.
module tb_wishbone_sram_bridge;

    localparam int          NINST = 6;
    localparam logic [31:0] BASE  = 32'h3000_0000;

    typedef struct {
        bit          abort;
        bit          oor;
        bit          we;
        logic [7:0]  w;
        logic [3:0]  sel;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          port;
        int          lat;
        bit          oor_after;
    } exp_t;

    logic clk = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   cyc_cnt = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic int cfg_mode(int g);
        case (g)
            0: return 1;
            1, 2, 3: return 2;
            4: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_rl(int g);
        case (g)
            0, 1: return 1;
            2, 5: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int cfg_nr(int g);
        return (g == 5) ? 200 : 256;
    endfunction

    function automatic logic [31:0] init_val(int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    task automatic check(input string name, input int g, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got %0h, expected %0h (t=%0t)", name, g, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < NINST; g++) begin : g_inst
        localparam int P_MODE = cfg_mode(g);
        localparam int P_RL   = cfg_rl(g);
        localparam int P_NR   = cfg_nr(g);

        logic        rst_n = 1'b0;
        logic        stb = 1'b0, cyc = 1'b0, we_s = 1'b0;
        logic [3:0]  sel_s = '0;
        logic [31:0] adr_s = '0, dat_s = '0;
        logic        ack, oor, ram_clk0, ram_clk1;
        logic [31:0] dat_o;
        logic        ram_csb0, ram_web0, ram_csb1;
        logic [3:0]  ram_wmask0;
        logic [7:0]  ram_addr0, ram_addr1;
        logic [31:0] ram_dout0, ram_din0, ram_din1;

        exp_t        exp_q[$];
        int          n_csb = 0;
        int          start_cyc = 0;

        wishbone_sram_bridge #(
            .BASE_ADDR(BASE), .ADDR_WIDTH(8), .NUM_ROWS(P_NR),
            .MODE(P_MODE), .READ_LATENCY(P_RL)
        ) dut (
            .wb_clk_i(clk), .wb_rst_ni(rst_n),
            .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we_s),
            .wbs_sel_i(sel_s), .wbs_adr_i(adr_s), .wbs_dat_i(dat_s),
            .wbs_ack_o(ack), .wbs_dat_o(dat_o), .oor_o(oor),
            .ram_clk0(ram_clk0), .ram_csb0(ram_csb0), .ram_web0(ram_web0),
            .ram_wmask0(ram_wmask0), .ram_addr0(ram_addr0), .ram_dout0(ram_dout0),
            .ram_din0(ram_din0), .ram_clk1(ram_clk1), .ram_csb1(ram_csb1),
            .ram_addr1(ram_addr1), .ram_din1(ram_din1)
        );

        // SRAM stand-in: read data becomes valid READ_LATENCY-1 edges after sampling.
        bit [31:0]   smem [256];
        bit          swr  [256];
        logic [31:0] q0, q1;
        int          age0 = 0, age1 = 0;

        always @(posedge clk) begin
            if (!ram_csb0) begin
                if (!ram_web0) begin
                    smem[ram_addr0] <= merge(swr[ram_addr0] ? smem[ram_addr0] : init_val(int'(ram_addr0)),
                                             ram_dout0, ram_wmask0);
                    swr[ram_addr0]  <= 1'b1;
                end else begin
                    q0   <= swr[ram_addr0] ? smem[ram_addr0] : init_val(int'(ram_addr0));
                    age0 <= 0;
                end
            end else if (age0 < 8) begin
                age0 <= age0 + 1;
            end
            if (!ram_csb1) begin
                q1   <= swr[ram_addr1] ? smem[ram_addr1] : init_val(int'(ram_addr1));
                age1 <= 0;
            end else if (age1 < 8) begin
                age1 <= age1 + 1;
            end
        end

        assign ram_din0 = (age0 >= P_RL - 1) ? q0 : 32'hDEAD_BEEF;
        assign ram_din1 = (age1 >= P_RL - 1) ? q1 : 32'hDEAD_BEEF;

        // Monitor: checks SRAM strobes against the head expectation, pops on every ack.
        initial begin
            exp_t h;
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (!ram_csb0 || !ram_csb1) begin
                        n_csb++;
                        if (exp_q.size() == 0) begin
                            check("spurious_csb", g, 64'({ram_csb1, ram_csb0}), 64'(2'b11));
                        end else begin
                            h = exp_q[0];
                            check("csb_port", g, 64'({ram_csb1, ram_csb0}),
                                  64'((h.port == 1) ? 2'b01 : 2'b10));
                            check("ram_addr", g, 64'((h.port == 1) ? ram_addr1 : ram_addr0), 64'(h.w));
                            if (h.we) check("ram_wr", g, 64'({ram_web0, ram_wmask0, ram_dout0}),
                                            64'({1'b0, h.sel, h.wdata}));
                            else check("ram_rd_web", g, 64'(ram_web0), 64'(1'b1));
                        end
                    end
                    if (ack) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_ack", g, 64'(ack), 64'(0));
                        end else begin
                            h = exp_q.pop_front();
                            if (h.abort) begin
                                check("ack_on_abort", g, 64'(ack), 64'(0));
                            end else begin
                                check("rdata", g, 64'(dat_o), 64'(h.rdata));
                                check("ack_latency", g, 64'(cyc_cnt - start_cyc - 1), 64'(h.lat));
                                check("csb_count", g, 64'(n_csb), 64'(h.oor ? 0 : 1));
                                check("oor_flag", g, 64'(oor), 64'(h.oor_after));
                            end
                            n_csb = 0;
                        end
                    end
                end
            end
        end

        // Reference model state, owned by the driver.
        logic [31:0] ref_mem [256];
        logic [31:0] last_dat = '0;
        bit          oor_exp  = 1'b0;

        function automatic int port_of(logic [7:0] w);
            if (P_MODE == 1) return (int'(w) >= P_NR / 2) ? 1 : 0;
            if (P_MODE == 2) return int'(w) % 2;
            return 0;
        endfunction

        function automatic exp_t make_exp(bit we, logic [31:0] adr, logic [3:0] sel,
                                          logic [31:0] data, bit abort);
            exp_t h;
            bit   inr;
            h.w     = adr[9:2];
            inr     = (adr[31:10] == BASE[31:10]) && (int'(h.w) < P_NR);
            h.abort = abort;
            h.oor   = !inr;
            h.we    = we;
            h.sel   = sel;
            h.wdata = data;
            h.port  = (inr && !we) ? port_of(h.w) : 0;
            h.lat   = !inr ? 0 : (we ? 1 : 1 + P_RL);
            if (!abort) begin
                if (!inr) begin
                    oor_exp  = 1'b1;
                    last_dat = '0;
                end else if (we) begin
                    ref_mem[h.w] = merge(ref_mem[h.w], data, sel);
                end else begin
                    last_dat = ref_mem[h.w];
                end
            end
            h.rdata     = last_dat;
            h.oor_after = oor_exp;
            return h;
        endfunction

        task automatic raise(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                             input logic [31:0] data);
            @(posedge clk); #1;
            stb = 1'b1; cyc = 1'b1; we_s = we; sel_s = sel; adr_s = adr; dat_s = data;
            start_cyc = cyc_cnt;
        endtask

        task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                            input logic [31:0] data);
            bit got;
            exp_q.push_back(make_exp(we, adr, sel, data, 1'b0));
            raise(we, adr, sel, data);
            got = 1'b0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (ack) begin
                    got = 1'b1;
                    break;
                end
            end
            if (!got) begin
                check("ack_timeout", g, 64'(got), 64'(1));
                exp_q.delete();
                n_csb = 0;
            end
            @(posedge clk); #1;
            stb = 1'b0; cyc = 1'b0;
        endtask

        task automatic rst_checks();
            check("rst_ctrl", g, 64'({ack, oor, ram_csb0, ram_csb1, ram_web0}), 64'(5'b00111));
            check("rst_mask_addr", g, 64'({ram_wmask0, ram_addr0, ram_addr1}), 64'(0));
            check("rst_data", g, 64'({dat_o, ram_dout0}), 64'(0));
        endtask

        task automatic abort_read(input logic [31:0] adr);
            exp_q.push_back(make_exp(1'b0, adr, 4'hF, 32'h0, 1'b1));
            raise(1'b0, adr, 4'hF, 32'h0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            stb = 1'b0; cyc = 1'b0;
            repeat (P_RL + 2) begin
                @(negedge clk);
                check("abort_no_ack", g, 64'(ack), 64'(0));
            end
            check("abort_dat_hold", g, 64'(dat_o), 64'(last_dat));
            exp_q.delete();
            n_csb = 0;
        endtask

        task automatic reset_mid_read(input logic [31:0] adr);
            exp_q.push_back(make_exp(1'b0, adr, 4'hF, 32'h0, 1'b1));
            raise(1'b0, adr, 4'hF, 32'h0);
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n = 1'b0;
            stb = 1'b0; cyc = 1'b0;
            repeat (3) begin
                @(posedge clk);
                @(negedge clk);
                rst_checks();
            end
            exp_q.delete();
            n_csb    = 0;
            last_dat = '0;
            oor_exp  = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
        endtask

        initial begin
            int          kind;
            logic [31:0] adr;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
            repeat (3) @(posedge clk);
            @(negedge clk);
            rst_checks();
            @(posedge clk); #1;
            rst_n = 1'b1;

            xfer(1'b1, 32'h3000_0010, 4'b0011, 32'hA5A5_1234);
            xfer(1'b0, 32'h3000_0010, 4'hF, 32'h0);
            xfer(1'b0, 32'h3000_0200, 4'hF, 32'h0);
            xfer(1'b0, 32'h3000_0014, 4'hF, 32'h0);
            xfer(1'b0, 32'h3000_0018, 4'hF, 32'h0);
            xfer(1'b0, 32'h3100_0000, 4'hF, 32'h0);
            xfer(1'b1, 32'h3000_04B0, 4'hF, 32'h1111_2222);
            xfer(1'b0, 32'h3000_0320, 4'hF, 32'h0);
            xfer(1'b1, 32'h3000_0000 | 32'(P_NR - 1) << 2, 4'hF, 32'hFEED_F00D);
            xfer(1'b0, 32'h3000_0000 | 32'(P_NR - 1) << 2, 4'hF, 32'h0);
            abort_read(32'h3000_0018);
            xfer(1'b0, 32'h3000_0018, 4'hF, 32'h0);
            xfer(1'b1, 32'h3000_0000, 4'hF, 32'h1357_9BDF);
            reset_mid_read(32'h3000_0000);
            xfer(1'b0, 32'h3000_0000, 4'hF, 32'h0);

            for (int n = 0; n < 60; n++) begin
                kind = $urandom_range(0, 9);
                if (kind == 0) adr = $urandom;
                else if (kind == 1) adr = BASE | (32'($urandom_range(0, 1023)) << 2);
                else adr = BASE | (32'($urandom_range(0, P_NR - 1)) << 2);
                adr = adr | 32'($urandom_range(0, 3));
                xfer(1'($urandom_range(0, 1)), adr, 4'($urandom_range(0, 15)), $urandom);
                repeat ($urandom_range(0, 2)) @(posedge clk);
            end
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 50000; i++) begin
            @(posedge clk);
            if (done_cnt == NINST) break;
        end
        if (done_cnt != NINST) check("global_timeout", -1, 64'(done_cnt), 64'(NINST));
        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
